pagerank_stream_engine: RTL and testbench
=========================================

Name: pagerank_stream_engine

Overview:
- Parametrised fixed-point successor to pagerank_DMP_serial.
- Replaces the fixed real-valued whole-graph array ports with a valid/ready edge stream.
- The host replays the edge list once per iteration. Node ranks are held internally, and the engine iterates until the max per-node delta falls below threshold or an iteration cap is reached.
- Final ranks are read back through a synchronous read port.

Parameters:
- NUM_NODES, 20, nodes in graph; ids 0..NUM_NODES-1.
- RANK_W, 32, unsigned fixed-point rank/coefficient width.
- FRAC_BITS, 16, fractional bits (1.0 = 2^FRAC_BITS).
- MAX_ITER, 64, iteration cap.
- ID_W, $clog2(NUM_NODES)+1, node id width.

Ports:
- clock  in  1  sole clock
- reset_n  in  1  synchronous active-low reset
- pagerank_enable  in  1  start pulse; sampled in IDLE/DONE only
- damping_factor  in  RANK_W  d in fixed point; sampled at start
- base_term  in  RANK_W  (1-d)/N precomputed by host; sampled at start
- init_rank  in  RANK_W  initial rank per node; sampled at start
- threshold  in  RANK_W  convergence threshold; sampled at start
- edge_req  out  1  high while engine awaits the current iteration's edges
- edge_valid  in  1  edge record valid
- edge_ready  out  1  engine accepts edge
- edge_src  in  ID_W  source node
- edge_dst  in  ID_W  destination node
- edge_inv_deg  in  RANK_W  1/out_degree(src), fixed point
- edge_last  in  1  final edge of this iteration
- rd_addr  in  ID_W  rank readout address
- rd_data  out  RANK_W  rank[rd_addr], 1-cycle latency
- iter_count  out  8  completed iterations
- converged  out  1  set in DONE if threshold met
- pagerank_complete  out  1  high while in DONE

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE. edge_req, edge_ready, converged, pagerank_complete, iter_count and rd_data are all 0. Rank arrays are not cleared.
- Reset mid-operation aborts immediately with the same values. Any partially streamed edges are discarded.
- IDLE/DONE + pagerank_enable: latch configuration, clear converged/iter_count, go to INIT. Enable is ignored in every other state.
- INIT, NUM_NODES cycles: cur[i]=init_rank, acc[i]=0, one node per cycle, then go to STREAM.
- STREAM:
  - edge_req=1 and edge_ready=1. Throughput is 1 edge/cycle; a transfer occurs when valid&&ready.
  - On transfer: acc[dst] += (cur[src]*edge_inv_deg)>>FRAC_BITS.
  - Product is 2*RANK_W wide, truncated. Accumulation saturates at 2^RANK_W-1.
  - src>=NUM_NODES contributes 0. dst>=NUM_NODES is dropped.
  - A transfer with edge_last goes to UPDATE. An edge-free graph sends one record with edge_inv_deg=0 and edge_last=1.
  - Gaps in edge_valid are legal and must not alter results.
- UPDATE, NUM_NODES cycles, node i per cycle:
  - nxt = base_term + (damping_factor*acc[i])>>FRAC_BITS, saturating.
  - delta=|nxt-cur[i]|; maxd=max(maxd,delta); cur[i]=nxt; acc[i]=0.
  - maxd is cleared on entry.
- CHECK, 1 cycle: iter_count++.
  - maxd<threshold: converged=1, go to DONE.
  - Otherwise, iter_count==MAX_ITER: converged=0, go to DONE.
  - Otherwise: go to STREAM.
- DONE: pagerank_complete=1 and held. rd_data <= cur[rd_addr] every cycle in any state. rd_addr>=NUM_NODES returns 0.
- threshold=0 never converges and always terminates at MAX_ITER.

Optional Feature:
- Macro PR_DELTA_L1_EN.
- Defined: the convergence metric is the L1 sum of |delta| over all nodes. The accumulator is RANK_W+$clog2(NUM_NODES) wide, saturating, and compared against threshold zero-extended.
- Undefined: the max-delta metric above is used.

Decomposition:
- Package pagerank_pkg holds:
  - the state enum (IDLE, INIT, STREAM, UPDATE, CHECK, DONE);
  - the fixed-point helper functions fx_mul (truncating, saturating) and sat_add;
  - FX_ONE=1<<FRAC_BITS.
- One sub-module, pagerank_fx_mac: a combinational multiply-shift-saturate-add shared by STREAM and UPDATE datapaths.

Test Plan:
- Steady-state ring:
  - Stimulus: N=4 (NUM_NODES=4), edges 0→1→2→3→0, inv_deg=65536, d=55705, base=2458, init=16384, threshold=16.
  - Required response: all ranks 16384, converged=1, iter_count=1.
- Iteration cap:
  - Stimulus: same graph, threshold=0, MAX_ITER=5.
  - Required response: complete after 5 iterations, converged=0, iter_count=5.
- Backpressure/gaps:
  - Stimulus: the ring with edge_valid toggled randomly (50%).
  - Required response: identical ranks and iter_count to the gapless run.
- Out-of-range ids:
  - Stimulus: add edge dst=7 (N=4) and edge src=9.
  - Required response: results identical to the ring alone; rd_addr=7 gives 0.
- Reset mid-STREAM:
  - Stimulus: reset_n low for 1 cycle after 2 edges, then restart.
  - Required response: outputs 0 during reset; restarted run matches the steady-state ring result.
- Saturation:
  - Stimulus: inv_deg=0xFFFFFFFF, init=0xFFFFFFFF.
  - Required response: ranks clamp at 0xFFFFFFFF with no wrap.

Source files
------------

// File: rtl/pagerank_pkg.sv
// Shared types and fixed-point helpers for the streaming PageRank engine.
// Helpers work on 64-bit containers; callers pass their real width and fraction.
package pagerank_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    STREAM,
    UPDATE,
    CHECK,
    DONE
  } pr_state_t;

  localparam int MAX_W = 64;
  localparam int PR_FRAC_BITS = 16;
  localparam logic [MAX_W-1:0] FX_ONE = 64'd1 << PR_FRAC_BITS;

  // Full-width product, fraction dropped, clamped to the largest w-bit value.
  function automatic logic [MAX_W-1:0] fx_mul(input logic [MAX_W-1:0] a,
                                               input logic [MAX_W-1:0] b,
                                               input int frac,
                                               input int w);
    logic [2*MAX_W-1:0] prod;
    logic [2*MAX_W-1:0] lim;
    prod = {{MAX_W{1'b0}}, a} * {{MAX_W{1'b0}}, b};
    prod = prod >> frac;
    lim  = ((2*MAX_W)'(1) << w) - (2*MAX_W)'(1);
    return (prod > lim) ? lim[MAX_W-1:0] : prod[MAX_W-1:0];
  endfunction

  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                input logic [MAX_W-1:0] b,
                                                input int w);
    logic [MAX_W:0] s;
    logic [MAX_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    return (s > lim) ? lim[MAX_W-1:0] : s[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/pagerank_fx_mac.sv
// Combinational multiply, drop fraction, saturate, then saturating add.
// Shared by the edge accumulation and the rank update datapaths.
module pagerank_fx_mac
  import pagerank_pkg::*;
#(
  parameter int RANK_W    = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic [RANK_W-1:0] mul_a,
  input  logic [RANK_W-1:0] mul_b,
  input  logic [RANK_W-1:0] addend,
  output logic [RANK_W-1:0] sum
);

  logic [MAX_W-1:0] prod;
  logic [MAX_W-1:0] total;

  assign prod  = fx_mul(MAX_W'(mul_a), MAX_W'(mul_b), FRAC_BITS, RANK_W);
  assign total = sat_add(MAX_W'(addend), prod, RANK_W);
  assign sum   = RANK_W'(total);

endmodule

// File: rtl/pagerank_stream_engine.sv
// Iterative fixed-point PageRank fed by a replayed valid/ready edge stream.
// Define PR_DELTA_L1_EN to use the L1 sum of rank deltas as convergence metric.
module pagerank_stream_engine
  import pagerank_pkg::*;
#(
  parameter int NUM_NODES = 20,
  parameter int RANK_W    = 32,
  parameter int FRAC_BITS = 16,
  parameter int MAX_ITER  = 64,
  parameter int ID_W      = $clog2(NUM_NODES) + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pagerank_enable,
  input  logic [RANK_W-1:0] damping_factor,
  input  logic [RANK_W-1:0] base_term,
  input  logic [RANK_W-1:0] init_rank,
  input  logic [RANK_W-1:0] threshold,
  output logic              edge_req,
  input  logic              edge_valid,
  output logic              edge_ready,
  input  logic [ID_W-1:0]   edge_src,
  input  logic [ID_W-1:0]   edge_dst,
  input  logic [RANK_W-1:0] edge_inv_deg,
  input  logic              edge_last,
  input  logic [ID_W-1:0]   rd_addr,
  output logic [RANK_W-1:0] rd_data,
  output logic [7:0]        iter_count,
  output logic              converged,
  output logic              pagerank_complete
);

  localparam int IDX_W = $clog2(NUM_NODES);
`ifdef PR_DELTA_L1_EN
  localparam int MET_W = RANK_W + $clog2(NUM_NODES);
`else
  localparam int MET_W = RANK_W;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);
  localparam logic [ID_W-1:0]  ID_LIMIT = ID_W'(NUM_NODES);

  pr_state_t state;
  logic [IDX_W-1:0]  node_idx;
  logic [RANK_W-1:0] cur [NUM_NODES];
  logic [RANK_W-1:0] acc [NUM_NODES];
  logic [RANK_W-1:0] damping_q;
  logic [RANK_W-1:0] base_q;
  logic [RANK_W-1:0] init_q;
  logic [RANK_W-1:0] thr_q;
  logic [MET_W-1:0]  metric;
  logic [MET_W-1:0]  metric_next;

  logic              src_ok;
  logic              dst_ok;
  logic              rd_ok;
  logic [IDX_W-1:0]  src_idx;
  logic [IDX_W-1:0]  dst_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              xfer;
  logic [RANK_W-1:0] mac_a;
  logic [RANK_W-1:0] mac_b;
  logic [RANK_W-1:0] mac_c;
  logic [RANK_W-1:0] mac_sum;
  logic [RANK_W-1:0] cur_node;
  logic [RANK_W-1:0] delta;

  assign src_ok   = edge_src < ID_LIMIT;
  assign dst_ok   = edge_dst < ID_LIMIT;
  assign rd_ok    = rd_addr < ID_LIMIT;
  assign src_idx  = edge_src[IDX_W-1:0];
  assign dst_idx  = edge_dst[IDX_W-1:0];
  assign rd_idx   = rd_addr[IDX_W-1:0];
  assign xfer     = edge_valid && edge_ready;
  assign cur_node = cur[node_idx];

  // One MAC serves both phases: edge contribution in STREAM, rank update in UPDATE.
  always_comb begin
    mac_a = src_ok ? cur[src_idx] : '0;
    mac_b = edge_inv_deg;
    mac_c = dst_ok ? acc[dst_idx] : '0;
    if (state == UPDATE) begin
      mac_a = damping_q;
      mac_b = acc[node_idx];
      mac_c = base_q;
    end
  end

  pagerank_fx_mac #(
    .RANK_W   (RANK_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_mac (
    .mul_a (mac_a),
    .mul_b (mac_b),
    .addend(mac_c),
    .sum   (mac_sum)
  );

  assign delta = (mac_sum >= cur_node) ? (mac_sum - cur_node) : (cur_node - mac_sum);

`ifdef PR_DELTA_L1_EN
  logic [MET_W:0] l1_sum;
  assign l1_sum      = {1'b0, metric} + {1'b0, MET_W'(delta)};
  assign metric_next = l1_sum[MET_W] ? '1 : l1_sum[MET_W-1:0];
`else
  assign metric_next = (delta > metric) ? delta : metric;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state             <= IDLE;
      node_idx          <= '0;
      metric            <= '0;
      edge_req          <= 1'b0;
      edge_ready        <= 1'b0;
      converged         <= 1'b0;
      pagerank_complete <= 1'b0;
      iter_count        <= '0;
      rd_data           <= '0;
    end else begin
      rd_data <= rd_ok ? cur[rd_idx] : '0;
      case (state)
        IDLE, DONE: begin
          if (pagerank_enable) begin
            damping_q         <= damping_factor;
            base_q            <= base_term;
            init_q            <= init_rank;
            thr_q             <= threshold;
            converged         <= 1'b0;
            iter_count        <= '0;
            pagerank_complete <= 1'b0;
            node_idx          <= '0;
            state             <= INIT;
          end
        end
        INIT: begin
          cur[node_idx] <= init_q;
          acc[node_idx] <= '0;
          if (node_idx == LAST_IDX) begin
            node_idx   <= '0;
            edge_req   <= 1'b1;
            edge_ready <= 1'b1;
            state      <= STREAM;
          end else begin
            node_idx <= node_idx + 1'b1;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (dst_ok) acc[dst_idx] <= mac_sum;
            if (edge_last) begin
              edge_req   <= 1'b0;
              edge_ready <= 1'b0;
              metric     <= '0;
              state      <= UPDATE;
            end
          end
        end
        UPDATE: begin
          cur[node_idx] <= mac_sum;
          acc[node_idx] <= '0;
          metric        <= metric_next;
          if (node_idx == LAST_IDX) begin
            node_idx <= '0;
            state    <= CHECK;
          end else begin
            node_idx <= node_idx + 1'b1;
          end
        end
        CHECK: begin
          iter_count <= iter_count + 8'd1;
          // Convergence takes priority over the iteration cap on the same pass.
          if (metric < MET_W'(thr_q)) begin
            converged         <= 1'b1;
            pagerank_complete <= 1'b1;
            state             <= DONE;
          end else if (iter_count + 8'd1 == 8'(MAX_ITER)) begin
            converged         <= 1'b0;
            pagerank_complete <= 1'b1;
            state             <= DONE;
          end else begin
            edge_req   <= 1'b1;
            edge_ready <= 1'b1;
            state      <= STREAM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pagerank_stream_engine.sv
// Self-checking bench: directed table rows, reset corner case, and randomized
// graphs compared against an iteration-level arithmetic model.
module tb_pagerank_stream_engine;
  import pagerank_pkg::*;

  localparam int N  = 4;
  localparam int RW = 32;
  localparam int FB = 16;
  localparam int MI = 5;
  localparam int IW = 4;
  localparam longint unsigned RMAX = 64'hFFFF_FFFF;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          pagerank_enable;
  logic [RW-1:0] damping_factor, base_term, init_rank, threshold;
  logic          edge_req, edge_valid, edge_ready, edge_last;
  logic [IW-1:0] edge_src, edge_dst, rd_addr;
  logic [RW-1:0] edge_inv_deg, rd_data;
  logic [7:0]    iter_count;
  logic          converged, pagerank_complete;

  always #5 clock = ~clock;

  pagerank_stream_engine #(
    .NUM_NODES(N), .RANK_W(RW), .FRAC_BITS(FB), .MAX_ITER(MI), .ID_W(IW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pagerank_enable(pagerank_enable),
    .damping_factor(damping_factor), .base_term(base_term),
    .init_rank(init_rank), .threshold(threshold),
    .edge_req(edge_req), .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_src(edge_src), .edge_dst(edge_dst), .edge_inv_deg(edge_inv_deg),
    .edge_last(edge_last), .rd_addr(rd_addr), .rd_data(rd_data),
    .iter_count(iter_count), .converged(converged),
    .pagerank_complete(pagerank_complete)
  );

  typedef struct {
    logic [IW-1:0] src;
    logic [IW-1:0] dst;
    logic [RW-1:0] inv;
  } edge_t;

  typedef struct {
    string         name;
    logic [RW-1:0] thr, init, d, base, inv;
    bit            gaps;
    bit            oor;
    logic [RW-1:0] exp_rank;
    bit            exp_conv;
    int            exp_iter;
  } vec_t;

  int    vec_count = 0;
  int    miscompares = 0;
  edge_t edges[$];
  vec_t  vecs[5];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic build_ring(input bit oor, input logic [RW-1:0] inv);
    edges.delete();
    if (oor) begin
      edges.push_back('{src: 4'd0, dst: 4'd7, inv: inv});
      edges.push_back('{src: 4'd9, dst: 4'd1, inv: inv});
    end
    for (int i = 0; i < N; i++)
      edges.push_back('{src: IW'(i), dst: IW'((i + 1) % N), inv: inv});
  endtask

  // Runs one full computation; streams the edge list once per requested iteration.
  task automatic apply_stimulus(input logic [RW-1:0] thr, input logic [RW-1:0] init,
                                input logic [RW-1:0] d, input logic [RW-1:0] base,
                                input bit gaps);
    int budget = 2000;
    int passes = 0;
    bit done = 0;
    threshold = thr; init_rank = init; damping_factor = d; base_term = base;
    pagerank_enable = 1'b1;
    tick();
    pagerank_enable = 1'b0;
    while (!done) begin
      while (!edge_req && !pagerank_complete && budget > 0) begin
        tick();
        budget--;
      end
      if (budget == 0 || passes > MI + 1) begin
        vec_count++;
        miscompares++;
        $display("[TB] FAIL completion timeout: got no completion, expected done within bound");
        done = 1;
      end else if (pagerank_complete) begin
        done = 1;
      end else begin
        passes++;
        for (int i = 0; i < edges.size(); i++) begin
          if (gaps) begin
            while ($urandom_range(0, 1) == 0) begin
              edge_valid = 1'b0;
              tick();
            end
          end
          edge_valid   = 1'b1;
          edge_src     = edges[i].src;
          edge_dst     = edges[i].dst;
          edge_inv_deg = edges[i].inv;
          edge_last    = (i == edges.size() - 1);
          tick();
        end
        edge_valid = 1'b0;
        edge_last  = 1'b0;
      end
    end
  endtask

  task automatic read_ranks(output logic [RW-1:0] r [N]);
    for (int i = 0; i < N; i++) begin
      rd_addr = IW'(i);
      tick();
      r[i] = rd_data;
    end
  endtask

  // Iteration-level reference: whole-array passes with plain saturating arithmetic.
  task automatic model_run(input logic [RW-1:0] thr, input logic [RW-1:0] init,
                           input logic [RW-1:0] d, input logic [RW-1:0] base,
                           output logic [RW-1:0] r [N], output bit conv, output int it);
    longint unsigned cur[N], acc[N], nxt, contrib, dl, met;
`ifdef PR_DELTA_L1_EN
    longint unsigned met_max = (64'd1 << (RW + $clog2(N))) - 1;
`endif
    for (int n = 0; n < N; n++) cur[n] = init;
    it = 0;
    conv = 0;
    while (1) begin
      for (int n = 0; n < N; n++) acc[n] = 0;
      foreach (edges[k]) begin
        if (edges[k].src < N && edges[k].dst < N) begin
          contrib = (cur[edges[k].src] * longint'(edges[k].inv)) >> FB;
          if (contrib > RMAX) contrib = RMAX;
          acc[edges[k].dst] = acc[edges[k].dst] + contrib;
          if (acc[edges[k].dst] > RMAX) acc[edges[k].dst] = RMAX;
        end
      end
      met = 0;
      for (int n = 0; n < N; n++) begin
        contrib = (longint'(d) * acc[n]) >> FB;
        if (contrib > RMAX) contrib = RMAX;
        nxt = longint'(base) + contrib;
        if (nxt > RMAX) nxt = RMAX;
        dl = (nxt > cur[n]) ? nxt - cur[n] : cur[n] - nxt;
`ifdef PR_DELTA_L1_EN
        met = met + dl;
        if (met > met_max) met = met_max;
`else
        if (dl > met) met = dl;
`endif
        cur[n] = nxt;
      end
      it++;
      if (met < longint'(thr)) begin
        conv = 1;
        break;
      end
      if (it == MI) break;
    end
    for (int n = 0; n < N; n++) r[n] = RW'(cur[n]);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [RW-1:0] ranks [N];
    logic [RW-1:0] mranks [N];
    bit            mconv;
    int            miter;
    logic [RW-1:0] ring_inv;

    ring_inv = RW'(FX_ONE);
    vecs[0] = '{"ring",  32'd16, 32'd16384, 32'd55705, 32'd2458, ring_inv, 0, 0, 32'd16384, 1, 1};
    vecs[1] = '{"cap",   32'd0,  32'd16384, 32'd55705, 32'd2458, ring_inv, 0, 0, 32'd16384, 0, MI};
    vecs[2] = '{"gaps",  32'd16, 32'd16384, 32'd55705, 32'd2458, ring_inv, 1, 0, 32'd16384, 1, 1};
    vecs[3] = '{"oor",   32'd16, 32'd16384, 32'd55705, 32'd2458, ring_inv, 1, 1, 32'd16384, 1, 1};
    vecs[4] = '{"sat",   32'd16, 32'hFFFF_FFFF, 32'd131072, 32'd2458, 32'hFFFF_FFFF, 0, 0,
                32'hFFFF_FFFF, 1, 1};

    reset_n = 1'b0; pagerank_enable = 1'b0; edge_valid = 1'b0; edge_last = 1'b0;
    edge_src = '0; edge_dst = '0; edge_inv_deg = '0; rd_addr = '0;
    damping_factor = '0; base_term = '0; init_rank = '0; threshold = '0;
    tick(); tick();
    check_output("reset edge_req", edge_req, 0);
    check_output("reset edge_ready", edge_ready, 0);
    check_output("reset complete", pagerank_complete, 0);
    check_output("reset converged", converged, 0);
    check_output("reset iter_count", iter_count, 0);
    check_output("reset rd_data", rd_data, 0);
    reset_n = 1'b1;
    tick();

    foreach (vecs[v]) begin
      build_ring(vecs[v].oor, vecs[v].inv);
      apply_stimulus(vecs[v].thr, vecs[v].init, vecs[v].d, vecs[v].base, vecs[v].gaps);
      check_output({vecs[v].name, " complete"}, pagerank_complete, 1);
      check_output({vecs[v].name, " converged"}, converged, vecs[v].exp_conv);
      check_output({vecs[v].name, " iter_count"}, iter_count, vecs[v].exp_iter);
      read_ranks(ranks);
      for (int i = 0; i < N; i++)
        check_output($sformatf("%s rank%0d", vecs[v].name, i), ranks[i], vecs[v].exp_rank);
      rd_addr = 4'd7;
      tick();
      check_output({vecs[v].name, " rd_addr7"}, rd_data, 0);
    end

    // Abort two edges into a pass, then confirm a clean restart.
    build_ring(0, ring_inv);
    rd_addr = '0;
    threshold = 32'd16; init_rank = 32'd16384; damping_factor = 32'd55705; base_term = 32'd2458;
    pagerank_enable = 1'b1;
    tick();
    pagerank_enable = 1'b0;
    for (int t = 0; t < 50 && !edge_req; t++) tick();
    check_output("midrst edge_req", edge_req, 1);
    for (int i = 0; i < 2; i++) begin
      edge_valid = 1'b1; edge_src = edges[i].src; edge_dst = edges[i].dst;
      edge_inv_deg = edges[i].inv; edge_last = 1'b0;
      tick();
    end
    edge_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    check_output("midrst edge_req low", edge_req, 0);
    check_output("midrst edge_ready low", edge_ready, 0);
    check_output("midrst rd_data", rd_data, 0);
    check_output("midrst iter_count", iter_count, 0);
    check_output("midrst complete", pagerank_complete, 0);
    reset_n = 1'b1;
    tick();
    apply_stimulus(32'd16, 32'd16384, 32'd55705, 32'd2458, 0);
    check_output("restart converged", converged, 1);
    check_output("restart iter_count", iter_count, 1);
    read_ranks(ranks);
    for (int i = 0; i < N; i++)
      check_output($sformatf("restart rank%0d", i), ranks[i], 32'd16384);

    for (int k = 0; k < 8; k++) begin
      int ne;
      logic [RW-1:0] thr, init, d, base;
      bit gaps;
      edges.delete();
      ne = $urandom_range(0, 8);
      for (int e = 0; e < ne; e++) begin
        edge_t ed;
        ed.src = IW'($urandom_range(0, 5));
        ed.dst = IW'($urandom_range(0, 5));
        ed.inv = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : RW'($urandom_range(0, 65536));
        edges.push_back(ed);
      end
      if (ne == 0) edges.push_back('{src: 4'd0, dst: 4'd0, inv: 32'd0});
      thr  = RW'($urandom_range(0, 3000));
      init = (k == 7) ? RW'($urandom) : RW'($urandom_range(0, 65536));
      d    = RW'($urandom_range(0, 65536));
      base = RW'($urandom_range(0, 8192));
      gaps = bit'($urandom_range(0, 1));
      model_run(thr, init, d, base, mranks, mconv, miter);
      apply_stimulus(thr, init, d, base, gaps);
      check_output($sformatf("rand%0d complete", k), pagerank_complete, 1);
      check_output($sformatf("rand%0d converged", k), converged, mconv);
      check_output($sformatf("rand%0d iter_count", k), iter_count, miter);
      read_ranks(ranks);
      for (int i = 0; i < N; i++)
        check_output($sformatf("rand%0d rank%0d", k, i), ranks[i], mranks[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
